carry_select_adder: RTL and testbench
=====================================

// Module: carry_select_adder
// PURPOSE
//   Registered 64-bit carry-select adder computing {c_out,sum} = a + b + c_in.
//   The operand is split into fixed-size blocks. Each upper block precomputes
//   its result for carry-in 0 and for carry-in 1, then muxes on the incoming
//   block carry. Used as the wide-add datapath element.
//   The result is registered once, so downstream logic sees a clean, timed value.
// PARAMETERS
//   WIDTH  64  operand/sum width in bits
//   BLOCK  8   carry-select block width; WIDTH % BLOCK == 0 is required
// PORTS
//   clk    input   1      single clock; all state updates on rising edge
//   rst_n  input   1      asynchronous, active-low reset
//   a      input   WIDTH  operand A (unsigned)
//   b      input   WIDTH  operand B (unsigned)
//   c_in   input   1      carry into bit 0
//   sum    output  WIDTH  registered sum bits [WIDTH-1:0]
//   c_out  output  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//   - Reset: rst_n low immediately forces sum=0 and c_out=0, with no dependency
//     on clk. Outputs hold 0 while rst_n is low.
//   - Reset release: the first rising clk edge with rst_n high loads a result.
//   - Latency: exactly 1 cycle. a, b and c_in are sampled at posedge N, and
//     {c_out,sum} shows the result from posedge N onward.
//   - No handshake; a new result is loaded on every cycle.
//   - Arithmetic: unsigned, modulo 2^(WIDTH+1). c_out is bit WIDTH of
//     a + b + c_in. There is no overflow flag.
//   - Block 0 (bits BLOCK-1:0): a single ripple-carry adder fed by c_in.
//   - Block k>0: two ripple-carry adders, one with carry-in 0 and one with
//     carry-in 1. A mux selects sum and block carry using the carry out of
//     block k-1. The carry out of the final block is c_out.
//   - Build the ripple chains from full-adder cells (generate loops).
//   - Do not use a behavioural '+' in the datapath.
//   - Full propagate case: a = all ones, b = 0, c_in = 1. The carry must pass
//     through every block select and give sum = 0, c_out = 1.
//   - Maximum case: a = b = all ones, c_in = 1. Result is sum = all ones,
//     c_out = 1.
//   - Inputs may change every cycle. Only values stable at the clock edge
//     matter, and the combinational path must settle within one period.
//   - A reset asserted mid-stream discards the pending result. After release,
//     the first valid output reflects inputs at the first post-release edge.
// TESTING
//   - The bench compares every cycle against a behavioural reference model
//     ({c_out,sum} = a + b + c_in, delayed 1 cycle).
//   - The bench flags any mismatch and prints a, b and c_in.
//   - Scenarios:
//     - Zero: a=0, b=0, c_in=0 -> sum=0, c_out=0.
//     - Full propagate: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0,
//       c_out=1.
//     - Maximum: a=b=64'hFFFF_FFFF_FFFF_FFFF, c_in=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF,
//       c_out=1.
//     - No carry-in: a=all ones, b=0, c_in=0 -> sum=all ones, c_out=0.
//     - a=b=all ones, c_in=0 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=1.
//     - Block-boundary carry: a=b=64'hFF, c_in=0 -> sum=64'h1FE, c_out=0.
//     - Block-boundary carry: a=b=64'hFF, c_in=1 -> sum=64'h1FF, c_out=0.
//   - Reset: assert rst_n=0 between clock edges while outputs are nonzero.
//     sum and c_out must go to 0 at once, with no clock edge.
//     After release, the result appears 1 cycle after the first edge.
//   - Random: 10k random a, b, c_in vectors, one per cycle. Expect zero
//     mismatches against the reference model with 1-cycle latency.

Source files
------------

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {c_out,sum} = a + b + c_in, one cycle latency.
// Block 0 ripples from c_in; each upper block ripples twice (carry-in 0 and 1)
// and the incoming block carry picks the result.

// Single-bit full-adder cell.
module csa_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// Ripple-carry adder of W bits built from a chain of full-adder cells.
module csa_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    csa_fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (s_o[i]),
      .c_o (c[i+1])
    );
  end

  assign c_o = c[W];
endmodule

module carry_select_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 8   // WIDTH must be a multiple of BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int NBLK = WIDTH / BLOCK;

  logic [NBLK:0]      blk_c;   // carry into each block; blk_c[NBLK] is the final carry
  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;

  assign blk_c[0] = c_in;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_first
      // Lowest block has a known carry-in, so a single ripple suffices.
      csa_rca #(.W(BLOCK)) u_rca (
        .a_i (a[k*BLOCK +: BLOCK]),
        .b_i (b[k*BLOCK +: BLOCK]),
        .c_i (blk_c[k]),
        .s_o (sum_d[k*BLOCK +: BLOCK]),
        .c_o (blk_c[k+1])
      );
    end else begin : g_sel
      logic [BLOCK-1:0] s_c0;
      logic [BLOCK-1:0] s_c1;
      logic             co_c0;
      logic             co_c1;

      csa_rca #(.W(BLOCK)) u_rca0 (
        .a_i (a[k*BLOCK +: BLOCK]),
        .b_i (b[k*BLOCK +: BLOCK]),
        .c_i (1'b0),
        .s_o (s_c0),
        .c_o (co_c0)
      );

      csa_rca #(.W(BLOCK)) u_rca1 (
        .a_i (a[k*BLOCK +: BLOCK]),
        .b_i (b[k*BLOCK +: BLOCK]),
        .c_i (1'b1),
        .s_o (s_c1),
        .c_o (co_c1)
      );

      // Only the block-carry mux sits on the long carry path.
      assign sum_d[k*BLOCK +: BLOCK] = blk_c[k] ? s_c1  : s_c0;
      assign blk_c[k+1]              = blk_c[k] ? co_c1 : co_c0;
    end
  end

  // Result register; reset clears outputs immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= blk_c[NBLK];
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
endmodule

// File: tb/tb_carry_select_adder.sv
// Directed and random checks of the registered 64-bit carry-select adder.
module tb_carry_select_adder;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;

  int checks = 0;
  int errors = 0;

  carry_select_adder #(.WIDTH(W), .BLOCK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] exp);
    logic [W:0] obs;
    obs = {c_out, sum};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s a=%h b=%h c_in=%b got=%h want=%h", tag, a, b, c_in, obs, exp);
    end
  endtask

  // Drive one vector between edges, then sample just after the loading edge.
  task automatic step(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic [W:0] exp);
    @(negedge clk);
    a = av; b = bv; c_in = ci;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   ref_v;

    rst_n = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; c_in = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_state", 65'h0);
    @(posedge clk); #1;
    check("reset_hold_edge", 65'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("zero",          64'h0, 64'h0, 1'b0, 65'h0);
    step("full_prop",     ONES,  64'h0, 1'b1, {1'b1, 64'h0});
    step("max",           ONES,  ONES,  1'b1, {1'b1, ONES});
    step("no_cin",        ONES,  64'h0, 1'b0, {1'b0, ONES});
    step("ones_ones_c0",  ONES,  ONES,  1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    step("blk_bound_c0",  64'hFF, 64'hFF, 1'b0, {1'b0, 64'h1FE});
    step("blk_bound_c1",  64'hFF, 64'hFF, 1'b1, {1'b0, 64'h1FF});
    step("alt_prop",      64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
                          {1'b1, 64'h0});
    step("alt_noprop",    64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
                          {1'b0, ONES});
    step("mid_carry",     64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
                          {1'b0, 64'h0000_0001_0000_0000});
    step("top_blk_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                          {1'b1, 64'h0});
    step("mixed",         64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
                          {1'b1, 64'h0});
    step("nonzero_pre_rst", ONES, ONES, 1'b1, {1'b1, ONES});

    // Asynchronous reset between edges while outputs are nonzero.
    #3 rst_n = 1'b0;
    #1 check("reset_async", 65'h0);
    @(negedge clk);
    a = ONES; b = ONES; c_in = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_hold", 65'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 64'hFF; b = 64'hFF; c_in = 1'b1;
    @(posedge clk); #1;
    check("post_release", {1'b0, 64'h1FF});

    // Random vectors, one per cycle, against a behavioural reference.
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (i % 16 == 0) rb = ~ra;   // stress long carry propagation
      ref_v = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
      step("random", ra, rb, rc, ref_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
